sd_spi_master: RTL and testbench
================================

Name: sd_spi_master

Overview:
- Hardware SPI mode-0 master that replaces the bit-banged SD-card GPIO port.
- Sits between the CPU IO decode (phi-synchronous write/read ticks) and the sd_mosi/sd_clk/sd_ssel_n/sd_miso pins.
- CPU ports:
  - 0xF2: control (write) and status (read).
  - 0xF3: transmit/start (write) and received byte (read).
- Top level does the address decode, provides the ticks, and drives the CPU bus from rx_data/status.

Parameters:
- DEFAULT_DIV, 11: reset value of the 4-bit clock divider; SCK half-period = (div+1) clk cycles (~384 kHz at 9.216 MHz phi).
- IDLE_MOSI, 1: level of sd_mosi when no transfer is active.

Ports:
- clk  in  1  phi (CPU clock); all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_ctrl_tick  in  1  one-cycle strobe: CPU wrote port 0xF2.
- wr_data_tick  in  1  one-cycle strobe: CPU wrote port 0xF3.
- rd_status_tick  in  1  one-cycle strobe: CPU read port 0xF2.
- din  in  8  CPU data bus, valid while any tick is high.
- rx_data  out  8  last received byte.
- status  out  8  {busy, overrun, 5'b0, ssel_active}.
- sd_clk  out  1  SPI SCK.
- sd_mosi  out  1  SPI MOSI.
- sd_ssel_n  out  1  SD chip select, active low.
- sd_miso  in  1  SPI MISO (already stable at phi rate; no synchroniser needed).

Behaviour:
- Reset values:
  - sd_clk=0, sd_mosi=IDLE_MOSI, sd_ssel_n=1, rx_data=8'hFF.
  - div=DEFAULT_DIV, busy=0, overrun=0, state IDLE.
  - Reset mid-transfer aborts immediately to these values; no partial rx_data update.
- Control write (wr_ctrl_tick, state IDLE):
  - ssel_active <= din[0]; sd_ssel_n = ~ssel_active.
  - div <= din[7:4].
  - Other bits are ignored.
- Data write (wr_data_tick, state IDLE): shift <= din, bitcnt <= 0, cnt <= div, state <= SCK_LO, busy=1 from the next cycle.
- Every state transition below is registered; there are no combinational pin paths.
- FSM states IDLE, SCK_LO, SCK_HI:
  - SCK_LO:
    - sd_clk=0, sd_mosi=shift[7].
    - cnt decrements each cycle.
    - At cnt==0: sd_clk<=1, rxsh <= {rxsh[6:0], sd_miso}, cnt<=div, state<=SCK_HI.
  - SCK_HI:
    - cnt decrements each cycle.
    - At cnt==0 and bitcnt==7: sd_clk<=0, rx_data <= completed rxsh, shift<=8'hFF, state<=IDLE, busy<=0.
    - At cnt==0 otherwise: sd_clk<=0, shift<=shift<<1, bitcnt++, cnt<=div, state<=SCK_LO.
- Timing:
  - MSB first. MISO is sampled on the SCK rising edge; MOSI changes on the falling edge.
  - Transfer length = 16*(div+1) clk cycles from the cycle after wr_data_tick to busy=0.
  - rx_data and busy=0 update on the same edge.
- Overrun (any write while busy):
  - The write is ignored, and overrun <= 1.
  - Both ssel and div are unchanged; the transfer in flight is unaffected.
- Simultaneous wr_ctrl_tick and wr_data_tick: ctrl is applied, data is ignored, overrun <= 1.
- rd_status_tick:
  - status is combinational from registers, so the read returns the current overrun.
  - overrun clears on that same clk edge.
  - If an overrun-causing write happens on the same edge, set wins.
- sd_ssel_n is never changed by the FSM; deassertion between bytes is software-controlled only.
- 4-bit counters: cnt wraps never (reloaded at 0); bitcnt is 3 bits, terminal value 7.

Decomposition:
- Shared package:
  - state enum (IDLE, SCK_LO, SCK_HI).
  - STATUS_BUSY=7, STATUS_OVR=6, STATUS_SSEL=0.
  - CTRL_SSEL=0, CTRL_DIV_MSB=7, CTRL_DIV_LSB=4.
  - Port constants 8'hF2/8'hF3 for the top-level decoder.
- Single module; no sub-module is natural. The divider counter and shifters are too small to split.

Test Plan:
- Reset then idle:
  - Required: sd_ssel_n=1, sd_clk=0, sd_mosi=1, rx_data=FF, status=00.
  - Required: divider gives a 12-cycle half-period on the first transfer.
- Ctrl write 0x01, then data write 0xA5 with MISO looped back to MOSI:
  - Required: busy for exactly 16*(0+1)=16 cycles and 8 SCK rising edges.
  - Required: MOSI bit sequence 1,0,1,0,0,1,0,1.
  - Required: rx_data=A5 and status=01 afterwards.
- Ctrl 0xF1 (div 15), data 0x3C with MISO driven 0x96 MSB-first:
  - Required: 256-cycle transfer, each SCK half-period 16 cycles, rx_data=96.
- Data write 0x55 during a transfer:
  - Required: status bit6=1, and the original byte completes unaltered.
  - Required: the next rd_status_tick returns 0xC1 (busy, overrun, ssel), then the following read shows bit6=0.
- Ctrl write 0x00 while busy:
  - Required: sd_ssel_n stays 0, overrun=1.
  - Required: ctrl 0x00 after busy drops gives sd_ssel_n=1.
- Reset asserted at cycle 5 of a transfer:
  - Required: next cycle sd_clk=0, sd_mosi=1, sd_ssel_n=1, busy=0, rx_data=FF.

Source files
------------

// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD-card SPI master: FSM states, register bit positions, IO ports.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sd_spi_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCK_LO = 2'd1,
      ST_SCK_HI = 2'd2
   } spi_state_t;

   // Status register bit positions (port 0xF2 read)
   localparam int STATUS_BUSY  = 7;
   localparam int STATUS_OVR   = 6;
   localparam int STATUS_SSEL  = 0;

   // Control register bit positions (port 0xF2 write)
   localparam int CTRL_SSEL    = 0;
   localparam int CTRL_DIV_MSB = 7;
   localparam int CTRL_DIV_LSB = 4;

   // CPU IO port addresses used by the enclosing address decoder
   localparam logic [7:0] PORT_CTRL = 8'hF2;
   localparam logic [7:0] PORT_DATA = 8'hF3;

endpackage

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for the SD card; CPU writes ctrl/data ticks, reads status/rx_data.
// Latency: 16*(div+1) clk cycles per byte from the cycle after the data write to busy=0.
// Backpressure: none; writes arriving while busy are dropped and flagged in the overrun bit.
module sd_spi_master
   import sd_spi_master_pkg::*;
#(
   parameter int       DEFAULT_DIV = 11,
   parameter logic     IDLE_MOSI   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ctrl_tick,
   input  logic       wr_data_tick,
   input  logic       rd_status_tick,
   input  logic [7:0] din,
   output logic [7:0] rx_data,
   output logic [7:0] status,
   output logic       sd_clk,
   output logic       sd_mosi,
   output logic       sd_ssel_n,
   input  logic       sd_miso
);

   spi_state_t state_q;
   logic [3:0] div_q;
   logic [3:0] cnt_q;
   logic [2:0] bitcnt_q;
   logic [7:0] shift_q;
   logic [7:0] rxsh_q;
   logic [7:0] rx_data_q;
   logic       ssel_q;
   logic       busy_q;
   logic       overrun_q;
   logic       sck_q;
   logic       mosi_q;
   logic       ovr_set_d;

   // A write is an overrun if it lands while a byte is in flight, or if both ticks collide.
   always_comb begin
      ovr_set_d = 1'b0;
      if (busy_q && (wr_ctrl_tick || wr_data_tick)) begin
         ovr_set_d = 1'b1;
      end else if (wr_ctrl_tick && wr_data_tick) begin
         ovr_set_d = 1'b1;
      end
   end

   // Byte-transfer FSM; every pin is a register, MOSI is preloaded with the next bit on SCK fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         div_q     <= 4'(DEFAULT_DIV);
         cnt_q     <= 4'd0;
         bitcnt_q  <= 3'd0;
         shift_q   <= 8'hFF;
         rxsh_q    <= 8'h00;
         rx_data_q <= 8'hFF;
         ssel_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         sck_q     <= 1'b0;
         mosi_q    <= IDLE_MOSI;
      end else begin
         // set wins over a same-cycle status read clear
         if (ovr_set_d) begin
            overrun_q <= 1'b1;
         end else if (rd_status_tick) begin
            overrun_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (wr_ctrl_tick) begin
                  ssel_q <= din[CTRL_SSEL];
                  div_q  <= din[CTRL_DIV_MSB:CTRL_DIV_LSB];
               end else if (wr_data_tick) begin
                  shift_q  <= din;
                  bitcnt_q <= 3'd0;
                  cnt_q    <= div_q;
                  state_q  <= ST_SCK_LO;
                  busy_q   <= 1'b1;
                  mosi_q   <= din[7];
               end
            end
            ST_SCK_LO: begin
               if (cnt_q == 4'd0) begin
                  sck_q   <= 1'b1;
                  rxsh_q  <= {rxsh_q[6:0], sd_miso};
                  cnt_q   <= div_q;
                  state_q <= ST_SCK_HI;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_SCK_HI: begin
               if (cnt_q == 4'd0) begin
                  sck_q <= 1'b0;
                  if (bitcnt_q == 3'd7) begin
                     rx_data_q <= rxsh_q;
                     shift_q   <= 8'hFF;
                     state_q   <= ST_IDLE;
                     busy_q    <= 1'b0;
                     mosi_q    <= IDLE_MOSI;
                  end else begin
                     shift_q  <= {shift_q[6:0], 1'b0};
                     bitcnt_q <= bitcnt_q + 3'd1;
                     cnt_q    <= div_q;
                     state_q  <= ST_SCK_LO;
                     mosi_q   <= shift_q[6];
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               sck_q   <= 1'b0;
               mosi_q  <= IDLE_MOSI;
            end
         endcase
      end
   end

   // Status is read straight from registers so a read sees the overrun before it clears.
   always_comb begin
      status              = 8'h00;
      status[STATUS_BUSY] = busy_q;
      status[STATUS_OVR]  = overrun_q;
      status[STATUS_SSEL] = ssel_q;
   end

   assign rx_data   = rx_data_q;
   assign sd_clk    = sck_q;
   assign sd_mosi   = mosi_q;
   assign sd_ssel_n = ~ssel_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: expected byte results queued at each data write,
// checked by a monitor when busy drops.
// Stimulus driven 1 time unit after posedge; monitor samples on negedge.
module tb_sd_spi_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_ctrl_tick;
   logic       wr_data_tick;
   logic       rd_status_tick;
   logic [7:0] din;
   logic [7:0] rx_data;
   logic [7:0] status;
   logic       sd_clk;
   logic       sd_mosi;
   logic       sd_ssel_n;
   logic       sd_miso;

   typedef struct {
      logic [7:0] rx;
      logic [7:0] mosi;
      int         half;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic       loop_en = 1'b1;
   logic [7:0] miso_pat = 8'h00;
   int         rises = 0;
   logic [2:0] miso_idx;

   int         busy_cyc = 0;
   int         run = 0;
   int         min_h = 0;
   int         max_h = 0;
   int         n_runs = 0;
   logic [7:0] mbits = 8'h00;
   logic       prev_busy = 1'b0;
   logic       prev_sck = 1'b0;

   always #5 clk = ~clk;

   sd_spi_master #(.DEFAULT_DIV(11), .IDLE_MOSI(1'b1)) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_ctrl_tick   (wr_ctrl_tick),
      .wr_data_tick   (wr_data_tick),
      .rd_status_tick (rd_status_tick),
      .din            (din),
      .rx_data        (rx_data),
      .status         (status),
      .sd_clk         (sd_clk),
      .sd_mosi        (sd_mosi),
      .sd_ssel_n      (sd_ssel_n),
      .sd_miso        (sd_miso)
   );

   // slave model: loopback, or present pattern bit k before the k-th SCK rise
   always_comb miso_idx = 3'd7 - rises[2:0];
   assign sd_miso = loop_en ? sd_mosi : miso_pat[miso_idx];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_ctrl(input logic [7:0] v);
      din = v;
      wr_ctrl_tick = 1'b1;
      cyc();
      wr_ctrl_tick = 1'b0;
   endtask

   task automatic wr_data(input logic [7:0] v);
      din = v;
      wr_data_tick = 1'b1;
      cyc();
      wr_data_tick = 1'b0;
   endtask

   // data write issued while idle: queue what the monitor must see
   task automatic start_xfer(input logic [7:0] v, input logic [7:0] exp_rx, input int half);
      exp_t e;
      e.rx   = exp_rx;
      e.mosi = v;
      e.half = half;
      sb.push_back(e);
      wr_data(v);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (status[7] === 1'b1 && n < 2000) begin
         cyc();
         n++;
      end
      check(tag, {31'd0, status[7]}, 32'd0);
      cyc();
   endtask

   // monitor: measure each transfer and compare against the queued expectation
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         sb.delete();
         prev_busy = 1'b0;
         prev_sck  = 1'b0;
      end else begin
         if (status[7] && !prev_busy) begin
            busy_cyc = 0;
            rises    = 0;
            mbits    = 8'h00;
            run      = 0;
            n_runs   = 0;
            min_h    = 9999;
            max_h    = 0;
         end
         if (status[7]) begin
            busy_cyc++;
            if (sd_clk && !prev_sck) begin
               rises++;
               mbits = {mbits[6:0], sd_mosi};
            end
            if (run > 0 && sd_clk != prev_sck) begin
               if (run < min_h) min_h = run;
               if (run > max_h) max_h = run;
               n_runs++;
               run = 1;
            end else begin
               run++;
            end
         end
         if (!status[7] && prev_busy) begin
            exp_t e;
            if (run < min_h) min_h = run;
            if (run > max_h) max_h = run;
            n_runs++;
            check("sb_avail", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
               check("mosi_seq", {24'd0, mbits}, {24'd0, e.mosi});
               check("sck_rises", rises, 8);
               check("busy_cycles", busy_cyc, 16 * e.half);
               check("half_min", min_h, e.half);
               check("half_max", max_h, e.half);
               check("half_count", n_runs, 16);
               check("sck_idle", {31'd0, sd_clk}, 32'd0);
               check("mosi_idle", {31'd0, sd_mosi}, 32'd1);
            end
         end
         prev_busy = status[7];
         prev_sck  = sd_clk;
      end
   end

   initial begin
      reset          = 1'b1;
      wr_ctrl_tick   = 1'b0;
      wr_data_tick   = 1'b0;
      rd_status_tick = 1'b0;
      din            = 8'h00;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();

      // reset / idle state
      check("rst_ssel_n", {31'd0, sd_ssel_n}, 32'd1);
      check("rst_sck",    {31'd0, sd_clk},    32'd0);
      check("rst_mosi",   {31'd0, sd_mosi},   32'd1);
      check("rst_rx",     {24'd0, rx_data},   32'hFF);
      check("rst_status", {24'd0, status},    32'h00);

      // default divider: 12-cycle half-period
      loop_en = 1'b1;
      start_xfer(8'hC3, 8'hC3, 12);
      wait_idle("idle_default");

      // div 0, ssel on, loopback of 0xA5
      wr_ctrl(8'h01);
      check("ssel_on", {31'd0, sd_ssel_n}, 32'd0);
      start_xfer(8'hA5, 8'hA5, 1);
      check("busy_set", {31'd0, status[7]}, 32'd1);
      wait_idle("idle_a5");
      check("status_a5", {24'd0, status}, 32'h01);
      check("rx_a5", {24'd0, rx_data}, 32'hA5);

      // div 15, slave returns 0x96 while master sends 0x3C
      wr_ctrl(8'hF1);
      loop_en  = 1'b0;
      miso_pat = 8'h96;
      start_xfer(8'h3C, 8'h96, 16);
      repeat (20) cyc();

      // overrun: data write while busy
      wr_data(8'h55);
      check("ovr_set", {31'd0, status[6]}, 32'd1);
      rd_status_tick = 1'b1;
      check("rd_status_c1", {24'd0, status}, 32'hC1);
      cyc();
      check("ovr_clr_now", {31'd0, status[6]}, 32'd0);
      check("rd_status_c1b", {24'd0, status}, 32'h81);
      cyc();
      rd_status_tick = 1'b0;

      // ctrl write while busy is ignored
      wr_ctrl(8'h00);
      check("busy_ctrl_ssel", {31'd0, sd_ssel_n}, 32'd0);
      check("busy_ctrl_ovr", {31'd0, status[6]}, 32'd1);

      // set wins over a same-edge status read
      din = 8'h12;
      wr_data_tick   = 1'b1;
      rd_status_tick = 1'b1;
      cyc();
      wr_data_tick   = 1'b0;
      rd_status_tick = 1'b0;
      check("ovr_set_wins", {31'd0, status[6]}, 32'd1);

      wait_idle("idle_3c");
      check("rx_96", {24'd0, rx_data}, 32'h96);
      wr_ctrl(8'h00);
      check("ssel_off", {31'd0, sd_ssel_n}, 32'd1);

      // simultaneous ctrl+data while idle: ctrl applied, data dropped, overrun
      din = 8'h21;
      wr_ctrl_tick = 1'b1;
      wr_data_tick = 1'b1;
      cyc();
      wr_ctrl_tick = 1'b0;
      wr_data_tick = 1'b0;
      check("both_status", {24'd0, status}, 32'h41);
      repeat (3) cyc();
      check("both_no_xfer", {31'd0, status[7]}, 32'd0);

      // reset in cycle 5 of a transfer
      loop_en = 1'b1;
      wr_ctrl(8'h51);
      start_xfer(8'h00, 8'h00, 6);
      repeat (4) cyc();
      check("pre_rst_busy", {31'd0, status[7]}, 32'd1);
      reset = 1'b1;
      cyc();
      check("mid_rst_sck",  {31'd0, sd_clk},    32'd0);
      check("mid_rst_mosi", {31'd0, sd_mosi},   32'd1);
      check("mid_rst_ssel", {31'd0, sd_ssel_n}, 32'd1);
      check("mid_rst_busy", {31'd0, status[7]}, 32'd0);
      check("mid_rst_rx",   {24'd0, rx_data},   32'hFF);
      reset = 1'b0;
      repeat (3) cyc();
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
